alu_flagged_seq: RTL and testbench

ALU_FLAGGED_SEQ -- requirements
Module: alu_flagged_seq

---
 rtl/alu_flagged_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_flagged_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flagged_seq.sv
// alu_flagged_seq: registered ALU with status flags. All operations except
// MUL complete in one cycle; MUL runs a shift-add loop, one multiplier bit per
// cycle, during which the block refuses new requests.
module alu_flagged_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH:0]   full_result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_ADC = 3'b101,
      OP_MUL = 3'b110,
      OP_SHL = 3'b111
   } op_t;

   typedef enum logic {
      IDLE,
      MUL_BUSY
   } state_t;

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t             state;
   state_t             state_next;
   logic               mul_done;
   logic               accept;
   logic               start_mul;

   logic [WIDTH:0]     op_full;
   logic               op_carry;
   logic               op_ovf;

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] mcand_sh;
   logic [WIDTH-1:0]   mplier;
   logic [CNT_W-1:0]   step;
   logic               mul_carry;

   assign in_ready  = (state == IDLE);
   assign busy      = (state == MUL_BUSY);
   assign accept    = in_valid && in_ready;
   assign start_mul = accept && (op_t'(sel) == OP_MUL);

   // State register; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next state: leave IDLE on an accepted MUL, return after the last step.
   always_comb begin
      state_next = state;
      mul_done   = 1'b0;
      case (state)
         IDLE:     if (start_mul) state_next = MUL_BUSY;
         MUL_BUSY: begin
            if (step == LAST_STEP) begin
               state_next = IDLE;
               mul_done   = 1'b1;
            end
         end
         default:  state_next = IDLE;
      endcase
   end

   // Single-cycle result, carry and signed overflow for the current request.
   // ADC reads the carry flag register, i.e. the value held at accept time.
   always_comb begin
      op_full  = '0;
      op_carry = 1'b0;
      op_ovf   = 1'b0;
      case (op_t'(sel))
         OP_ADD: begin
            op_full  = {1'b0, a} + {1'b0, b};
            op_carry = op_full[WIDTH];
            op_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (op_full[WIDTH-1] != a[WIDTH-1]);
         end
         OP_ADC: begin
            op_full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry};
            op_carry = op_full[WIDTH];
            op_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (op_full[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            op_full  = {1'b0, a} - {1'b0, b};
            op_carry = op_full[WIDTH];
            op_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (op_full[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: op_full = {1'b0, a & b};
         OP_OR:  op_full = {1'b0, a | b};
         OP_XOR: op_full = {1'b0, a ^ b};
         OP_SHL: begin
            op_full  = {a, 1'b0};
            op_carry = a[WIDTH-1];
         end
         OP_MUL: op_full = '0;
         default: op_full = '0;
      endcase
   end

   // One shift-add step: add the shifted multiplicand when the current
   // multiplier LSB is set.
   assign acc_next  = acc + (mplier[0] ? mcand_sh : '0);
   assign mul_carry = |acc_next[2*WIDTH-1:WIDTH];

   // Multiplier working registers: load on accept, step once per busy cycle.
   // NOTE: these carry no reset; they are always loaded on accept before being read.
   always_ff @(posedge clk) begin
      if (start_mul) begin
         acc      <= '0;
         mcand_sh <= {{WIDTH{1'b0}}, a};
         mplier   <= b;
         step     <= '0;
      end else if (state == MUL_BUSY) begin
         acc      <= acc_next;
         mcand_sh <= mcand_sh << 1;
         mplier   <= mplier >> 1;
         step     <= step + 1'b1;
      end
   end

   // Output registers: written only when a result completes, held otherwise;
   // out_valid is a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         y           <= '0;
         full_result <= '0;
         zero        <= 1'b0;
         negative    <= 1'b0;
         carry       <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (mul_done) begin
            out_valid   <= 1'b1;
            y           <= acc_next[WIDTH-1:0];
            full_result <= {mul_carry, acc_next[WIDTH-1:0]};
            zero        <= (acc_next[WIDTH-1:0] == '0);
            negative    <= acc_next[WIDTH-1];
            carry       <= mul_carry;
            overflow    <= 1'b0;
         end else if (accept && !start_mul) begin
            out_valid   <= 1'b1;
            y           <= op_full[WIDTH-1:0];
            full_result <= {op_carry, op_full[WIDTH-1:0]};
            zero        <= (op_full[WIDTH-1:0] == '0);
            negative    <= op_full[WIDTH-1];
            carry       <= op_carry;
            overflow    <= op_ovf;
         end
      end
   end

endmodule

// File: tb/tb_alu_flagged_seq.sv
// Bench for alu_flagged_seq: a 4-bit and an 8-bit instance, each compared
// every cycle against a transaction-level reference model, plus literal
// expectations for the documented example operations.
module tb_alu_flagged_seq;

   typedef struct {
      longint full;
      bit     z, n, c, v;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       v4, v8;
   logic [2:0] s4, s8;
   logic [3:0] a4, b4;
   logic [7:0] a8, b8;

   logic       r4, r8, bz4, bz8, ov4, ov8;
   logic [3:0] y4;
   logic [4:0] f4;
   logic [7:0] y8;
   logic [8:0] f8;
   logic       z4, n4, c4, o4, z8, n8, c8, o8;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // reference model state, one slot per instance (0: WIDTH=4, 1: WIDTH=8)
   longint m_full[2];
   bit     m_z[2], m_n[2], m_c[2], m_v[2], m_ov[2];
   int     m_cnt[2];
   res_t   m_mul[2];

   always #5 clk = ~clk;

   alu_flagged_seq #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .a(a4), .b(b4),
      .sel(s4), .out_valid(ov4), .y(y4), .full_result(f4), .zero(z4),
      .negative(n4), .carry(c4), .overflow(o4), .busy(bz4));

   alu_flagged_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
      .sel(s8), .out_valid(ov8), .y(y8), .full_result(f8), .zero(z8),
      .negative(n8), .carry(c8), .overflow(o8), .busy(bz8));

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Result of one operation computed from the opcode definitions.
   function automatic res_t alu_ref(input int w, input logic [2:0] s,
                                    input longint a, input longint b, input bit cin);
      res_t   r;
      longint mask = (longint'(1) << w) - 1;
      longint msb  = longint'(1) << (w - 1);
      longint p;
      bit     sa, sb, sy;
      r.c = 1'b0;
      r.v = 1'b0;
      case (s)
         3'd0:    r.full = a + b;
         3'd5:    r.full = a + b + longint'(cin);
         3'd1:    r.full = (a - b) & ((longint'(1) << (w + 1)) - 1);
         3'd2:    r.full = a & b;
         3'd3:    r.full = a | b;
         3'd4:    r.full = a ^ b;
         3'd7:    r.full = a << 1;
         default: begin
            p      = a * b;
            r.c    = (p >> w) != 0;
            r.full = (p & mask) | (longint'(r.c) << w);
         end
      endcase
      if (s == 3'd0 || s == 3'd1 || s == 3'd5 || s == 3'd7) r.c = ((r.full >> w) & 1) != 0;
      r.z = (r.full & mask) == 0;
      r.n = (r.full & msb) != 0;
      sa  = (a & msb) != 0;
      sb  = (b & msb) != 0;
      sy  = r.n;
      if (s == 3'd0 || s == 3'd5) r.v = (sa == sb) && (sy != sa);
      if (s == 3'd1)              r.v = (sa != sb) && (sy != sa);
      return r;
   endfunction

   // Reference model: advance both instances on every rising edge.
   always @(posedge clk) begin
      int       w;
      bit       iv;
      logic [2:0] s;
      longint   aa, bb;
      res_t     r;
      for (int k = 0; k < 2; k++) begin
         w  = (k == 0) ? 4 : 8;
         iv = (k == 0) ? v4 : v8;
         s  = (k == 0) ? s4 : s8;
         aa = (k == 0) ? longint'(a4) : longint'(a8);
         bb = (k == 0) ? longint'(b4) : longint'(b8);
         if (!rst_n) begin
            m_full[k] = 0; m_z[k] = 0; m_n[k] = 0; m_c[k] = 0; m_v[k] = 0;
            m_ov[k] = 0; m_cnt[k] = 0;
         end else begin
            m_ov[k] = 1'b0;
            if (m_cnt[k] > 0) begin
               m_cnt[k]--;
               if (m_cnt[k] == 0) begin
                  r = m_mul[k];
                  m_full[k] = r.full; m_z[k] = r.z; m_n[k] = r.n; m_c[k] = r.c;
                  m_v[k] = r.v; m_ov[k] = 1'b1;
               end
            end else if (iv) begin
               r = alu_ref(w, s, aa, bb, m_c[k]);
               if (s == 3'd6) begin
                  m_mul[k] = r;
                  m_cnt[k] = w;
               end else begin
                  m_full[k] = r.full; m_z[k] = r.z; m_n[k] = r.n; m_c[k] = r.c;
                  m_v[k] = r.v; m_ov[k] = 1'b1;
               end
            end
         end
      end
   end

   task automatic cmp(input int k, input logic rdy, input logic bsy, input logic ov,
                      input logic [32:0] yy, input logic [32:0] ff,
                      input logic zz, input logic nn, input logic cc, input logic vv);
      int     w    = (k == 0) ? 4 : 8;
      longint mask = (longint'(1) << w) - 1;
      check($sformatf("w%0d.in_ready", w),    33'(rdy), 33'(m_cnt[k] == 0));
      check($sformatf("w%0d.busy", w),        33'(bsy), 33'(m_cnt[k] != 0));
      check($sformatf("w%0d.out_valid", w),   33'(ov),  33'(m_ov[k]));
      check($sformatf("w%0d.y", w),           yy,       33'(m_full[k] & mask));
      check($sformatf("w%0d.full_result", w), ff,       33'(m_full[k]));
      check($sformatf("w%0d.flags", w), {29'd0, zz, nn, cc, vv},
            {29'd0, m_z[k], m_n[k], m_c[k], m_v[k]});
   endtask

   // Compare both instances against the model on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp(0, r4, bz4, ov4, 33'(y4), 33'(f4), z4, n4, c4, o4);
         cmp(1, r8, bz8, ov8, 33'(y8), 33'(f8), z8, n8, c8, o8);
      end
   end

   // Present one op to the 4-bit instance; return just after the result edge.
   task automatic op4(input logic [2:0] s, input logic [3:0] x, input logic [3:0] z);
      @(posedge clk); #1;
      v4 = 1'b1; s4 = s; a4 = x; b4 = z;
      @(posedge clk); #1;
      v4 = 1'b0;
      @(negedge clk);
   endtask

   task automatic op8(input logic [2:0] s, input logic [7:0] x, input logic [7:0] z);
      @(posedge clk); #1;
      v8 = 1'b1; s8 = s; a8 = x; b8 = z;
      @(posedge clk); #1;
      v8 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      // reset with a request pending: it must not be accepted
      rst_n = 1'b0;
      v4 = 1'b1; s4 = 3'd0; a4 = 4'h1; b4 = 4'h1;
      v8 = 1'b1; s8 = 3'd0; a8 = 8'h1; b8 = 8'h1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1; v4 = 1'b0; v8 = 1'b0;
      @(negedge clk);
      check("reset.y",         33'(f4), 33'h0);
      check("reset.flags",     {29'd0, z4, n4, c4, o4}, 33'h0);
      check("reset.handshake", {30'd0, r4, bz4, ov4}, 33'b100);

      op4(3'd0, 4'b1111, 4'b0001);
      check("add_wrap.full",  33'(f4), 33'b10000);
      check("add_wrap.flags", {28'd0, ov4, z4, n4, c4, o4}, 33'b11010);

      op4(3'd1, 4'b0011, 4'b0101);
      check("sub_borrow.full",  33'(f4), 33'b11110);
      check("sub_borrow.flags", {29'd0, z4, n4, c4, o4}, 33'b0110);
      op4(3'd5, 4'b0001, 4'b0001);
      check("adc.y",     33'(y4), 33'b0011);
      check("adc.carry", 33'(c4), 33'b0);

      op4(3'd0, 4'b0111, 4'b0001);
      check("add_ovf.y",     33'(y4), 33'b1000);
      check("add_ovf.flags", {29'd0, z4, n4, c4, o4}, 33'b0101);

      // MUL 15*15 with an ADD presented throughout the busy period
      @(posedge clk); #1;
      v4 = 1'b1; s4 = 3'd6; a4 = 4'hF; b4 = 4'hF;
      @(posedge clk); #1;
      s4 = 3'd0; a4 = 4'h1; b4 = 4'h1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i < 5) check($sformatf("mul.busy%0d", i), {31'd0, r4, ov4}, 33'b00);
         else       check("mul.done", {31'd0, r4, ov4}, 33'b11);
         if (i == 4) v4 = 1'b0;
      end
      check("mul.full",  33'(f4), 33'b10001);
      check("mul.carry", 33'(c4), 33'b1);
      @(negedge clk);
      check("mul.hold", {28'd0, ov4, y4}, 33'b0_0001);

      // reset two cycles into a multiply
      @(posedge clk); #1;
      v4 = 1'b1; s4 = 3'd6; a4 = 4'hF; b4 = 4'hF;
      @(posedge clk); #1;
      v4 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0; v4 = 1'b1; s4 = 3'd4; a4 = 4'h5; b4 = 4'h3;
      @(posedge clk); #1;
      rst_n = 1'b1; v4 = 1'b0;
      @(negedge clk);
      check("mul_abort.regs", {23'd0, f4, z4, n4, c4, o4, ov4}, 33'h0);
      check("mul_abort.ready", {31'd0, r4, bz4}, 33'b10);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("mul_abort.no_pulse", 33'(ov4), 33'b0);
      end
      op4(3'd4, 4'b1010, 4'b1010);
      check("xor.y",    33'(y4), 33'b0000);
      check("xor.zero", 33'(z4), 33'b1);

      op8(3'd0, 8'hFF, 8'h01);
      check("add8.y",     33'(y8), 33'h00);
      check("add8.full",  33'(f8), 33'h100);
      check("add8.carry", 33'(c8), 33'b1);

      // back-to-back random single-cycle ops on both widths
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         v4 = 1'b1; v8 = 1'b1;
         s4 = 3'($urandom_range(0, 6)); if (s4 == 3'd6) s4 = 3'd7;
         s8 = 3'($urandom_range(0, 6)); if (s8 == 3'd6) s8 = 3'd7;
         a4 = 4'($urandom); b4 = 4'($urandom);
         a8 = 8'($urandom); b8 = 8'($urandom);
      end

      // mixed traffic: multiplies, idle gaps, occasional resets
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         rst_n = ($urandom_range(0, 249) != 0);
         v4 = ($urandom_range(0, 7) != 0);
         v8 = ($urandom_range(0, 7) != 0);
         s4 = 3'($urandom_range(0, 7));
         s8 = 3'($urandom_range(0, 7));
         a4 = 4'($urandom); b4 = 4'($urandom);
         a8 = 8'($urandom); b8 = 8'($urandom);
      end

      @(posedge clk); #1;
      rst_n = 1'b1; v4 = 1'b0; v8 = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
